// File: rtl/alu_ctrl_pkg.sv
// Shared codes for the ALU-control unit: alu_op/funct/select encodings, FSM states, clog2.
// ALU_CTRL_MULDIV_EN adds the BUSY state used by multi-cycle MULT/DIV sequencing.
package alu_ctrl_pkg;

  typedef enum logic [1:0] {
    ALUOP_ADD   = 2'd0,
    ALUOP_SUB   = 2'd1,
    ALUOP_RTYPE = 2'd2,
    ALUOP_OR    = 2'd3
  } alu_op_e;

  typedef enum logic [5:0] {
    FN_ADD  = 6'd0,
    FN_SUB  = 6'd1,
    FN_SLL  = 6'd2,
    FN_SLLV = 6'd3,
    FN_SRAV = 6'd4,
    FN_AND  = 6'd5,
    FN_OR   = 6'd6,
    FN_SLT  = 6'd7,
    FN_MULT = 6'd24,
    FN_DIV  = 6'd26
  } funct_e;

  typedef enum logic [3:0] {
    SEL_ADD  = 4'd0,
    SEL_SUB  = 4'd1,
    SEL_SLL  = 4'd2,
    SEL_SLLV = 4'd3,
    SEL_SRAV = 4'd4,
    SEL_AND  = 4'd5,
    SEL_OR   = 4'd6,
    SEL_SLT  = 4'd7,
    SEL_MULT = 4'd8,
    SEL_DIV  = 4'd9
  } alu_sel_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_VALID = 2'd1
`ifdef ALU_CTRL_MULDIV_EN
    ,
    ST_BUSY  = 2'd2
`endif
  } state_e;

  function automatic int unsigned clog2(input int unsigned value);
    int unsigned result;
    int unsigned v;
    result = 0;
    v = (value > 0) ? value - 1 : 0;
    while (v > 0) begin
      result = result + 1;
      v = v >> 1;
    end
    return (result == 0) ? 1 : result;
  endfunction

endpackage

// File: rtl/alu_ctrl_decode.sv
// Combinational {alu_op, funct} -> {sel, multi, illegal} decoder with a full default.
// MULT/DIV are recognised only when ALU_CTRL_MULDIV_EN is defined; otherwise they decode as illegal.
module alu_ctrl_decode
  import alu_ctrl_pkg::*;
#(
  parameter int unsigned OP_W    = 2,
  parameter int unsigned FUNCT_W = 6,
  parameter int unsigned SEL_W   = 4
) (
  input  logic [OP_W-1:0]    alu_op,
  input  logic [FUNCT_W-1:0] funct,
  output logic [SEL_W-1:0]   sel,
  output logic               multi,
  output logic               illegal
);

  alu_sel_e code;

  always_comb begin
    code    = SEL_ADD;
    multi   = 1'b0;
    illegal = 1'b0;
    case (32'(alu_op))
      32'(ALUOP_ADD): code = SEL_ADD;
      32'(ALUOP_SUB): code = SEL_SUB;
      32'(ALUOP_OR):  code = SEL_OR;
      32'(ALUOP_RTYPE): begin
        case (32'(funct))
          32'(FN_ADD):  code = SEL_ADD;
          32'(FN_SUB):  code = SEL_SUB;
          32'(FN_SLL):  code = SEL_SLL;
          32'(FN_SLLV): code = SEL_SLLV;
          32'(FN_SRAV): code = SEL_SRAV;
          32'(FN_AND):  code = SEL_AND;
          32'(FN_OR):   code = SEL_OR;
          32'(FN_SLT):  code = SEL_SLT;
`ifdef ALU_CTRL_MULDIV_EN
          32'(FN_MULT): begin
            code  = SEL_MULT;
            multi = 1'b1;
          end
          32'(FN_DIV): begin
            code  = SEL_DIV;
            multi = 1'b1;
          end
`endif
          default: begin
            code    = SEL_ADD;
            illegal = 1'b1;
          end
        endcase
      end
      default: begin
        code    = SEL_ADD;
        illegal = 1'b1;
      end
    endcase
  end

  always_comb begin
    sel = SEL_W'(code);
  end

endmodule

// File: rtl/alu_ctrl_seq.sv
// Registered, handshaked ALU-control unit: decode, valid/ready flow control, MULT/DIV select hold.
// ALU_CTRL_MULDIV_EN builds the BUSY state and countdown; without it every op is single-cycle.
module alu_ctrl_seq
  import alu_ctrl_pkg::*;
#(
  parameter int unsigned OP_W    = 2,
  parameter int unsigned FUNCT_W = 6,
  parameter int unsigned SEL_W   = 4,
  parameter int unsigned MUL_CYC = 4,
  parameter int unsigned DIV_CYC = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [OP_W-1:0]    alu_op,
  input  logic [FUNCT_W-1:0] funct,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [SEL_W-1:0]   alu_sel,
  output logic               multi,
  output logic               illegal
);

  if (MUL_CYC < 2 || DIV_CYC < 2 || SEL_W < 4) begin : g_param_check
    $error("alu_ctrl_seq: MUL_CYC and DIV_CYC must be >= 2, SEL_W must be >= 4");
  end

  state_e           state;
  logic [SEL_W-1:0] d_sel;
  logic             d_multi;
  logic             d_illegal;
  logic             accept;

`ifdef ALU_CTRL_MULDIV_EN
  localparam int unsigned CNT_W = clog2((MUL_CYC > DIV_CYC) ? MUL_CYC : DIV_CYC);
  logic [CNT_W-1:0] cnt;
`endif

  alu_ctrl_decode #(
    .OP_W   (OP_W),
    .FUNCT_W(FUNCT_W),
    .SEL_W  (SEL_W)
  ) u_decode (
    .alu_op (alu_op),
    .funct  (funct),
    .sel    (d_sel),
    .multi  (d_multi),
    .illegal(d_illegal)
  );

  // In VALID the slot frees exactly when execute consumes, giving single-entry pass-through.
  always_comb begin
    in_ready = 1'b0;
    if (!rst) begin
      case (state)
        ST_IDLE:  in_ready = 1'b1;
        ST_VALID: in_ready = out_ready;
        default:  in_ready = 1'b0;
      endcase
    end
  end

  always_comb begin
    accept = in_valid & in_ready;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      out_valid <= 1'b0;
      alu_sel   <= '0;
      multi     <= 1'b0;
      illegal   <= 1'b0;
`ifdef ALU_CTRL_MULDIV_EN
      cnt       <= '0;
`endif
    end else begin
      case (state)
        ST_IDLE, ST_VALID: begin
          if (accept) begin
            alu_sel <= d_sel;
            multi   <= d_multi;
            illegal <= d_illegal;
`ifdef ALU_CTRL_MULDIV_EN
            if (d_multi) begin
              state     <= ST_BUSY;
              out_valid <= 1'b0;
              cnt       <= (d_sel == SEL_W'(SEL_DIV)) ? CNT_W'(DIV_CYC - 1)
                                                      : CNT_W'(MUL_CYC - 1);
            end else begin
              state     <= ST_VALID;
              out_valid <= 1'b1;
            end
`else
            state     <= ST_VALID;
            out_valid <= 1'b1;
`endif
          end else if (state == ST_VALID && out_ready) begin
            state     <= ST_IDLE;
            out_valid <= 1'b0;
          end
        end
`ifdef ALU_CTRL_MULDIV_EN
        // VALID is entered on the edge where cnt reaches 0, so total latency equals the op's cycle count.
        ST_BUSY: begin
          cnt <= cnt - CNT_W'(1);
          if (cnt == CNT_W'(1)) begin
            state     <= ST_VALID;
            out_valid <= 1'b1;
          end
        end
`endif
        default: begin
          state     <= ST_IDLE;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_ctrl_seq.sv
// Directed bench for alu_ctrl_seq: scoreboard of expected selects, checked as results are consumed.
// Follows ALU_CTRL_MULDIV_EN the same way as the design.
module tb_alu_ctrl_seq;

  localparam int unsigned MUL = 4;
  localparam int unsigned DIV = 8;
`ifdef ALU_CTRL_MULDIV_EN
  localparam bit MD = 1'b1;
`else
  localparam bit MD = 1'b0;
`endif

  typedef struct packed {
    logic [3:0] sel;
    logic       multi;
    logic       illegal;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b1;
  logic       in_ready;
  logic [1:0] alu_op = 2'd2;
  logic [5:0] funct = 6'd4;
  logic       out_valid;
  logic       out_ready = 1'b1;
  logic [3:0] alu_sel;
  logic       multi;
  logic       illegal;

  exp_t sb[$];
  int unsigned tests = 0;
  int unsigned fails = 0;
  int unsigned nhs = 0;
  int unsigned cyc = 0;

  alu_ctrl_seq #(
    .OP_W   (2),
    .FUNCT_W(6),
    .SEL_W  (4),
    .MUL_CYC(MUL),
    .DIV_CYC(DIV)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .alu_op   (alu_op),
    .funct    (funct),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .alu_sel  (alu_sel),
    .multi    (multi),
    .illegal  (illegal)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t model(input logic [1:0] op, input logic [5:0] f);
    exp_t e;
    e = '{sel: 4'd0, multi: 1'b0, illegal: 1'b0};
    case (op)
      2'd0: e.sel = 4'd0;
      2'd1: e.sel = 4'd1;
      2'd3: e.sel = 4'd6;
      default: begin
        if (f <= 6'd7) e.sel = f[3:0];
        else if (MD && f == 6'd24) begin e.sel = 4'd8; e.multi = 1'b1; end
        else if (MD && f == 6'd26) begin e.sel = 4'd9; e.multi = 1'b1; end
        else e.illegal = 1'b1;
      end
    endcase
    return e;
  endfunction

  // Every consumed result must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      exp_t e;
      nhs++;
      if (sb.size() == 0) begin
        chk("spurious_out_valid", 32'(out_valid), 32'd0);
      end else begin
        e = sb.pop_front();
        chk("sel", 32'(alu_sel), 32'(e.sel));
        chk("multi", 32'(multi), 32'(e.multi));
        chk("illegal", 32'(illegal), 32'(e.illegal));
      end
    end
  end

  task automatic send(input logic [1:0] op, input logic [5:0] f);
    int unsigned n;
    n = 0;
    alu_op   = op;
    funct    = f;
    in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && n < 200) begin
      n++;
      @(negedge clk);
    end
    if (!in_ready) chk("accept_timeout", 32'(in_ready), 32'd1);
    else sb.push_back(model(op, f));
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic wait_result(input string tag, input int unsigned exp_lat, input int unsigned exp_stall);
    int unsigned n;
    int unsigned stall;
    n = 1;
    stall = 0;
    @(negedge clk);
    while (!out_valid && n < 64) begin
      if (!in_ready) stall++;
      n++;
      @(negedge clk);
    end
    chk({tag, "_latency"}, n, exp_lat);
    chk({tag, "_stall"}, stall, exp_stall);
  endtask

  task automatic idle(input int unsigned n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned c0;
    int unsigned h0;

    repeat (3) begin
      @(negedge clk);
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_alu_sel", 32'(alu_sel), 32'd0);
      chk("rst_in_ready", 32'(in_ready), 32'd0);
    end
    @(posedge clk);
    #1 rst = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    chk("post_rst_in_ready", 32'(in_ready), 32'd1);
    chk("post_rst_out_valid", 32'(out_valid), 32'd0);
    chk("post_rst_flags", {30'd0, multi, illegal}, 32'd0);
    idle(1);

    send(2'd2, 6'd4);
    wait_result("srav", 1, 0);
    idle(2);
    send(2'd2, 6'h3F);
    wait_result("illegal_3f", 1, 0);
    idle(2);
    send(2'd0, 6'd7);
    send(2'd1, 6'd24);
    send(2'd3, 6'd0);
    send(2'd2, 6'd8);
    idle(3);

    c0 = cyc;
    h0 = nhs;
    for (int i = 0; i < 8; i++) send(2'd2, 6'(i));
    @(negedge clk);
    #1;
    chk("stream_cycles", cyc - c0, 32'd8);
    chk("stream_results", nhs - h0, 32'd8);
    idle(2);

    send(2'd2, 6'd24);
    if (MD) wait_result("mult", MUL, MUL - 1);
    else wait_result("mult_off", 1, 0);
    idle(2);
    send(2'd2, 6'd26);
    if (MD) wait_result("div", DIV, DIV - 1);
    else wait_result("div_off", 1, 0);
    idle(2);

    out_ready = 1'b0;
    send(2'd2, 6'd5);
    alu_op   = 2'd2;
    funct    = 6'd6;
    in_valid = 1'b1;
    repeat (5) begin
      @(negedge clk);
      chk("bp_out_valid", 32'(out_valid), 32'd1);
      chk("bp_alu_sel", 32'(alu_sel), 32'd5);
      chk("bp_in_ready", 32'(in_ready), 32'd0);
    end
    @(posedge clk);
    #1 out_ready = 1'b1;
    send(2'd2, 6'd6);
    idle(3);

    out_ready = 1'b0;
    send(2'd2, 6'd1);
    @(negedge clk);
    chk("rstv_pre_valid", 32'(out_valid), 32'd1);
    @(posedge clk);
    #1 rst = 1'b1;
    void'(sb.pop_back());
    @(posedge clk);
    #1 rst = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    chk("rstv_out_valid", 32'(out_valid), 32'd0);
    chk("rstv_in_ready", 32'(in_ready), 32'd1);
    idle(2);

    if (MD) begin
      send(2'd2, 6'd26);
      repeat (4) @(posedge clk);
      #1 rst = 1'b1;
      void'(sb.pop_back());
      @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      chk("rstd_in_ready", 32'(in_ready), 32'd1);
      repeat (DIV + 2) begin
        @(negedge clk);
        chk("rstd_out_valid", 32'(out_valid), 32'd0);
      end
    end

    send(2'd2, 6'd3);
    wait_result("final", 1, 0);
    idle(4);
    chk("sb_drain", sb.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
